// File: rtl/pixel_gather_rr.sv
// Round-robin pixel gatherer: one private FIFO per ray-tracing core, drained in
// strict core order into a registered valid/ready stream with frame/line framing.
module pixel_gather_rr #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 12
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_CORES-1:0]           core_valid,
  input  logic [NUM_CORES*3*COLOR_W-1:0] core_data,
  output logic [NUM_CORES-1:0]           core_ready,
  input  logic [$clog2(NUM_CORES+1)-1:0] active_cores,
  input  logic [CNT_W-1:0]               line_width,
  input  logic [CNT_W-1:0]               frame_lines,
  input  logic                           out_ready,
  output logic [3*COLOR_W-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_user,
  output logic                           out_last,
  output logic                           busy
);

  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam int unsigned CFG_W = $clog2(NUM_CORES + 1);
  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [PIX_W-1:0] mem_q    [NUM_CORES][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CORES];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CORES];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CORES];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CORES];
  logic [OCC_W-1:0] occ_q    [NUM_CORES];
  logic [OCC_W-1:0] occ_d    [NUM_CORES];

  logic             run_q;
  logic [IDX_W-1:0] rr_idx_q, rr_idx_d;
  logic [CFG_W-1:0] cfg_n_q, cfg_n_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_user_q, out_user_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic [NUM_CORES-1:0] push;
  logic [NUM_CORES-1:0] pop_sel;
  logic                 pop;
  logic                 drained;
  logic                 line_end;
  logic [CFG_W-1:0]     cfg_clamp;
  logic [CFG_W-1:0]     rr_inc;
  logic [CNT_W-1:0]     lw_eff;
  logic [CNT_W-1:0]     fl_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness depends only on registered state; held low until the first edge after reset.
  always_comb begin
    core_ready = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_ready[i] = run_q && (CFG_W'(i) < cfg_n_q) && (occ_q[i] != OCC_W'(DEPTH));
    end
  end

  assign push = core_valid & core_ready;

  always_comb begin
    rr_idx_d    = rr_idx_q;
    cfg_n_d     = cfg_n_q;
    col_d       = col_q;
    row_d       = row_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    pop_sel     = '0;

    lw_eff = (line_width  == '0) ? CNT_W'(1) : line_width;
    fl_eff = (frame_lines == '0) ? CNT_W'(1) : frame_lines;

    drained = !out_valid_q;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (occ_q[i] != '0) drained = 1'b0;
    end

    if (active_cores == '0) begin
      cfg_clamp = CFG_W'(1);
    end else if (active_cores > CFG_W'(NUM_CORES)) begin
      cfg_clamp = CFG_W'(NUM_CORES);
    end else begin
      cfg_clamp = active_cores;
    end

    pop      = (occ_q[rr_idx_q] != '0) && (!out_valid_q || out_ready);
    line_end = (col_q == lw_eff - CNT_W'(1));
    rr_inc   = CFG_W'(rr_idx_q) + CFG_W'(1);

    if (pop) begin
      out_data_d  = mem_q[rr_idx_q][rd_ptr_q[rr_idx_q]];
      out_valid_d = 1'b1;
      out_user_d  = (col_q == '0) && (row_q == '0);
      out_last_d  = line_end;
      rr_idx_d    = (rr_inc == cfg_n_q) ? '0 : IDX_W'(rr_inc);
      if (line_end) begin
        col_d = '0;
        row_d = (row_q == fl_eff - CNT_W'(1)) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Core count only moves while nothing is in flight, so ordering never breaks.
    if (drained) begin
      cfg_n_d = cfg_clamp;
      if (cfg_clamp != cfg_n_q) rr_idx_d = '0;
    end

    busy_d = out_valid_d;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      pop_sel[i] = pop && (rr_idx_q == IDX_W'(i));
      if (push[i])    wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (pop_sel[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      case ({push[i], pop_sel[i]})
        2'b10:   occ_d[i] = occ_q[i] + OCC_W'(1);
        2'b01:   occ_d[i] = occ_q[i] - OCC_W'(1);
        default: occ_d[i] = occ_q[i];
      endcase
      if (occ_d[i] != '0) busy_d = 1'b1;
    end
  end

  // FIFO storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge aclk) begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= core_data[i*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
      run_q       <= 1'b0;
      rr_idx_q    <= '0;
      cfg_n_q     <= CFG_W'(1);
      col_q       <= '0;
      row_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      run_q       <= 1'b1;
      rr_idx_q    <= rr_idx_d;
      cfg_n_q     <= cfg_n_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_user  = out_user_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pixel_gather_rr.sv
// Bench for pixel_gather_rr: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the round-robin gatherer.
module tb_pixel_gather_rr;

  localparam int unsigned N       = 4;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 12;
  localparam int unsigned PIX_W   = 3 * COLOR_W;
  localparam int unsigned AC_W    = $clog2(N + 1);

  logic               aclk = 1'b0;
  logic               aresetn;
  logic [N-1:0]       core_valid;
  logic [N*PIX_W-1:0] core_data;
  logic [N-1:0]       core_ready;
  logic [AC_W-1:0]    active_cores;
  logic [CNT_W-1:0]   line_width;
  logic [CNT_W-1:0]   frame_lines;
  logic               out_ready;
  logic [PIX_W-1:0]   out_data;
  logic               out_valid;
  logic               out_user;
  logic               out_last;
  logic               busy;

  pixel_gather_rr #(
    .NUM_CORES(N), .COLOR_W(COLOR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .core_valid(core_valid), .core_data(core_data), .core_ready(core_ready),
    .active_cores(active_cores), .line_width(line_width), .frame_lines(frame_lines),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_user(out_user), .out_last(out_last), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [PIX_W-1:0] d;
    logic             u;
    logic             l;
  } beat_t;

  beat_t log_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model: one queue per core plus a flat pixel index within the frame.
  logic [PIX_W-1:0] m_q [N][$];
  int               m_rr, m_cfg, m_pix;
  bit               m_ov, m_user, m_last, m_run;
  logic [PIX_W-1:0] m_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_q[i].delete();
    m_rr = 0; m_cfg = 1; m_pix = 0;
    m_ov = 0; m_user = 0; m_last = 0; m_run = 0; m_od = '0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_run && (i < m_cfg) && (m_q[i].size() < DEPTH);
    return r;
  endfunction

  function automatic bit model_busy();
    bit b = m_ov;
    for (int i = 0; i < N; i++) if (m_q[i].size() != 0) b = 1;
    return b;
  endfunction

  task automatic model_edge();
    logic [N-1:0] rdy;
    int lw, fl, ac, c;
    bit drained;
    rdy = model_ready();
    lw = (line_width == 0) ? 1 : int'(line_width);
    fl = (frame_lines == 0) ? 1 : int'(frame_lines);
    drained = !model_busy();
    if (m_q[m_rr].size() != 0 && (!m_ov || out_ready)) begin
      m_od   = m_q[m_rr].pop_front();
      m_ov   = 1;
      m_user = (m_pix == 0);
      m_last = ((m_pix % lw) == lw - 1);
      m_pix  = (m_pix + 1) % (lw * fl);
      m_rr   = (m_rr + 1) % m_cfg;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (drained) begin
      ac = int'(active_cores);
      c  = (ac == 0) ? 1 : ((ac > N) ? N : ac);
      if (c != m_cfg) m_rr = 0;
      m_cfg = c;
    end
    for (int i = 0; i < N; i++)
      if (core_valid[i] && rdy[i]) m_q[i].push_back(core_data[i*PIX_W +: PIX_W]);
    m_run = 1;
  endtask

  // One clock: check readiness before the edge, advance model, check outputs after.
  task automatic step();
    chk("core_ready", 32'(core_ready), 32'(model_ready()));
    if (out_valid === 1'b1 && out_ready === 1'b1) log_q.push_back({out_data, out_user, out_last});
    model_edge();
    @(posedge aclk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("out_user",  32'(out_user),  32'(m_user));
    chk("out_last",  32'(out_last),  32'(m_last));
    chk("busy",      32'(busy),      32'(model_busy()));
  endtask

  task automatic set_core(input int c, input logic [PIX_W-1:0] d);
    core_data[c*PIX_W +: PIX_W] = d;
  endtask

  task automatic rand_step();
    core_valid = N'($urandom);
    for (int c = 0; c < N; c++) set_core(c, PIX_W'($urandom));
    out_ready = ($urandom % 4) != 0;
    step();
  endtask

  // Empties everything; refills an empty head core so stuck pixels elsewhere can leave.
  task automatic drain();
    int k = 0;
    bit any;
    out_ready = 1'b1;
    while (busy === 1'b1 && k < 200) begin
      core_valid = '0;
      any = 0;
      for (int i = 0; i < N; i++) if (m_q[i].size() != 0) any = 1;
      if (any && m_q[m_rr].size() == 0) begin
        core_valid[m_rr] = 1'b1;
        set_core(m_rr, PIX_W'($urandom));
      end
      step();
      k++;
    end
    core_valid = '0;
    chk("drain_done", 32'(busy), 32'(0));
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    aresetn = 1'b0; core_valid = '0; core_data = '0; out_ready = 1'b0;
    active_cores = AC_W'(4); line_width = CNT_W'(4); frame_lines = CNT_W'(2);
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data",  32'(out_data),  32'(0));
    chk("rst_out_user",  32'(out_user),  32'(0));
    chk("rst_out_last",  32'(out_last),  32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_core_ready", 32'(core_ready), 32'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();

    // Basic order: cores push 3,2,1,0; output must come out 0,1,2,3.
    out_ready = 1'b1;
    log_q.delete();
    for (int c = 3; c >= 0; c--) begin
      core_valid = '0;
      core_valid[c] = 1'b1;
      set_core(c, PIX_W'(32'h010101 * c));
      step();
    end
    core_valid = '0;
    drain();
    chk("basic_count", 32'(log_q.size()), 32'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < log_q.size()) begin
        chk("basic_data", 32'(log_q[k].d), 32'h010101 * k);
        chk("basic_user", 32'(log_q[k].u), 32'(k == 0));
        chk("basic_last", 32'(log_q[k].l), 32'(k == 3));
      end
    end

    // Backpressure on a single core.
    active_cores = AC_W'(1);
    step();
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      core_valid = N'(1);
      set_core(0, PIX_W'(32'hA00000 + k));
      if (core_ready[0] === 1'b1) acc++;
      step();
    end
    chk("bp_accepted", 32'(acc), 32'(3));
    chk("bp_ready_low", 32'(core_ready[0]), 32'(0));
    chk("bp_hold", 32'(out_data), 32'hA00000);
    core_valid = '0;
    log_q.delete();
    drain();
    chk("bp_count", 32'(log_q.size()), 32'(3));
    for (int k = 0; k < 3; k++)
      if (k < log_q.size()) chk("bp_data", 32'(log_q[k].d), 32'hA00000 + k);

    // Two active cores, then zero (treated as one).
    active_cores = AC_W'(2);
    step();
    chk("act2_ready", 32'(core_ready), 32'b0011);
    for (int k = 0; k < 60; k++) rand_step();
    drain();
    active_cores = AC_W'(0);
    step();
    chk("act0_ready", 32'(core_ready), 32'b0001);
    for (int k = 0; k < 40; k++) rand_step();
    drain();

    // Framing wrap: 3-pixel lines, 2-line frames.
    active_cores = AC_W'(1); line_width = CNT_W'(3); frame_lines = CNT_W'(2);
    apply_reset();
    log_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      core_valid = N'(1);
      set_core(0, PIX_W'(k + 1));
      step();
    end
    core_valid = '0;
    drain();
    chk("frame_count", 32'(log_q.size()), 32'(12));
    for (int k = 0; k < 12; k++) begin
      if (k < log_q.size()) begin
        chk("frame_user", 32'(log_q[k].u), 32'(k == 0 || k == 6));
        chk("frame_last", 32'(log_q[k].l), 32'(k == 2 || k == 5 || k == 8 || k == 11));
      end
    end

    // Empty head blocks output even while core 1 holds pixels.
    active_cores = AC_W'(2); line_width = CNT_W'(4); frame_lines = CNT_W'(2);
    apply_reset();
    log_q.delete();
    core_valid = N'(2);
    set_core(1, PIX_W'(32'h111111));
    step();
    set_core(1, PIX_W'(32'h222222));
    step();
    core_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 32'(out_valid), 32'(0));
    end
    core_valid = N'(1);
    set_core(0, PIX_W'(32'h0A0A0A));
    step();
    core_valid = '0;
    drain();
    if (log_q.size() >= 2) begin
      chk("stall_first", 32'(log_q[0].d), 32'h0A0A0A);
      chk("stall_second", 32'(log_q[1].d), 32'h111111);
    end else begin
      chk("stall_count", 32'(log_q.size()), 32'(2));
    end

    // Random soak with an over-range core count, then async reset mid-stream.
    active_cores = AC_W'(7);
    step();
    chk("clamp_ready", 32'(core_ready), 32'b1111);
    for (int k = 0; k < 300; k++) rand_step();
    out_ready = 1'b0;
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) begin
      core_valid = N'($urandom);
      for (int c = 0; c < N; c++) set_core(c, PIX_W'($urandom));
      step();
    end
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    aresetn = 1'b0;
    #2;
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_ready", 32'(core_ready), 32'(0));
    model_reset();
    core_valid = '0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
    log_q.delete();
    out_ready = 1'b1;
    core_valid = N'(1);
    set_core(0, PIX_W'(32'h5A5A5A));
    step();
    core_valid = '0;
    drain();
    if (log_q.size() >= 1) begin
      chk("post_rst_user", 32'(log_q[0].u), 32'(1));
      chk("post_rst_data", 32'(log_q[0].d), 32'h5A5A5A);
    end else begin
      chk("post_rst_count", 32'(log_q.size()), 32'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_gather_rr.md
Name: pixel_gather_rr

Overview:
- Parametrised successor of the single-slot pixel collector between the ray-tracing cores and the AXI-stream packer.
- Each of NUM_CORES cores gets a private FIFO. Pixels are emitted in strict round-robin core order (core 0,1,..,N-1,0,..) over a registered valid/ready output.
- Adds runtime core count, per-core buffering depth, and frame framing (out_user = start of frame, out_last = end of line) for the packer.

Parameters:
- NUM_CORES, 4, number of core input channels (1..16)
- COLOR_W, 8, bits per colour component
- DEPTH, 2, entries per core FIFO (power of 2, >=1)
- CNT_W, 12, width of line/column counters

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- core_valid  in  NUM_CORES  per-core pixel valid
- core_data  in  NUM_CORES*3*COLOR_W  per-core pixel; core i at slice i, packed {r,g,b}, r in MSBs
- core_ready  out  NUM_CORES  per-core accept
- active_cores  in  $clog2(NUM_CORES+1)  cores in use; 0 treated as 1, >NUM_CORES clamped
- line_width  in  CNT_W  pixels per line; 0 treated as 1
- frame_lines  in  CNT_W  lines per frame; 0 treated as 1
- out_ready  in  1  packer accept
- out_data  out  3*COLOR_W  pixel {r,g,b}
- out_valid  out  1  output valid
- out_user  out  1  first pixel of frame
- out_last  out  1  last pixel of line
- busy  out  1  any FIFO or the output register occupied

Behaviour:
- Reset (async assert, sync deassert internally not required): all FIFOs empty, rr_idx=0, col=0, row=0, cfg_n=1.
- Output values in reset: out_valid=0, out_data=0, out_user=0, out_last=0, busy=0, core_ready=0.
- Config latch: cfg_n <= clamp(active_cores) on every cycle the block is drained (all FIFOs empty, out_valid=0). On a change, rr_idx <= 0. Otherwise cfg_n holds.
- core_ready[i] = (i < cfg_n) && FIFO[i] not full. It is combinational from registered state only, with no dependence on core_valid.
- Push: core_valid[i] && core_ready[i] at a posedge writes core_data slice i. Inactive cores are never ready, and their valid is ignored.
- Pop condition: FIFO[rr_idx] non-empty && (!out_valid || out_ready).
- On pop:
  - Output register loads the head entry and sets out_valid=1.
  - rr_idx <= (rr_idx+1 == cfg_n) ? 0 : rr_idx+1.
- Framing on pop:
  - out_user=1 iff col==0 && row==0.
  - out_last=1 iff col==line_width-1.
  - col wraps to 0 at line end, and row then increments. row wraps to 0 after frame_lines-1.
- If out_valid && out_ready and no pop is possible, out_valid <= 0 next cycle.
- AXI rule: while out_valid=1 and out_ready=0, out_data/out_user/out_last are held stable.
- Latency: a pixel pushed at edge t into an empty FIFO that is rr_idx, with the output register free, is on out_data from edge t+1.
- Throughput: 1 pixel/cycle when the rr_idx FIFO stays non-empty and out_ready=1.
- Blocking: if FIFO[rr_idx] is empty, output stalls even when other FIFOs hold data. No skipping, so order is preserved.
- Push and pop on the same FIFO in one cycle is legal. Occupancy is unchanged. A full FIFO is not ready that cycle (no bypass).
- DEPTH=1 FIFO is full after one push.
- Counter arithmetic is CNT_W bits, and comparisons use line_width/frame_lines after the 0->1 substitution.
- Changing line_width or frame_lines mid-frame is undefined. Changing active_cores while not drained has no effect until drained.
- Reset asserted mid-transfer drops all buffered pixels. out_valid falls immediately (async).
- busy = |FIFO occupancy || out_valid.

Test Plan:
- Basic order: active_cores=4, line_width=4, frame_lines=2, out_ready=1. Cores 3,2,1,0 each push one pixel (0x030303..0x000000) on cycles 0..3 -> output 0x000000, 0x010101, 0x020202, 0x030303 in order, first with out_user=1, fourth with out_last=1.
- Backpressure: out_ready=0 for 5 cycles with DEPTH=2, core 0 pushing continuously -> core_ready[0] drops after 2 accepted plus 1 in the output register. out_data is held stable. After release, no pixel is lost or duplicated.
- Active count: active_cores=2 after drain -> core_ready[2], core_ready[3] stay 0, and output alternates core0/core1. active_cores=0 -> only core 0 is used.
- Framing wrap: line_width=3, frame_lines=2, 1 core, 12 pixels -> out_last on pixels 3,6,9,12 and out_user on pixels 1 and 7.
- Stall on empty head: core 1 has 2 pixels, core 0 empty, rr_idx=0 -> out_valid stays 0. When core 0 pushes, output is core0 then core1.
- Async reset mid-stream: assert aresetn=0 while out_valid=1 -> out_valid=0 and busy=0 without a clock edge, core_ready=0. After release, the first output again carries out_user=1.
